// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXI4-Stream arbiter/mux: S_INTF_NUM slaves onto one master.
// Optional per-port accepted-packet counters are built when AXIS_ARB_PKT_CNT_EN is defined.
module axis_pkt_rr_arbiter #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int S_INTF_NUM       = 2
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,
    input  logic [AXIS_DATA_WIDTH*S_INTF_NUM-1:0]     s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8*S_INTF_NUM-1:0]   s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH*S_INTF_NUM-1:0]    s_axis_tuser,
    input  logic [S_INTF_NUM-1:0]                     s_axis_tvalid,
    output logic [S_INTF_NUM-1:0]                     s_axis_tready,
    input  logic [S_INTF_NUM-1:0]                     s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    output logic [S_INTF_NUM-1:0]                     grant,
    output logic                                      busy,
    output logic [32*S_INTF_NUM-1:0]                  pkt_cnt
);

    localparam int SEL_WIDTH  = (S_INTF_NUM > 1) ? $clog2(S_INTF_NUM) : 1;
    localparam int KEEP_WIDTH = AXIS_DATA_WIDTH / 8;
    localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(S_INTF_NUM - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [SEL_WIDTH-1:0] sel, sel_nxt;
    logic [SEL_WIDTH-1:0] rr_ptr, rr_ptr_nxt;
    logic [SEL_WIDTH-1:0] pick, cand;
    logic                 pick_vld;
    logic                 last_accept;

    logic [AXIS_DATA_WIDTH-1:0]  s_data [S_INTF_NUM];
    logic [KEEP_WIDTH-1:0]       s_keep [S_INTF_NUM];
    logic [AXIS_TUSER_WIDTH-1:0] s_user [S_INTF_NUM];

    for (genvar i = 0; i < S_INTF_NUM; i++) begin : g_slice
        assign s_data[i] = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        assign s_keep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        assign s_user[i] = s_axis_tuser[i*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH];
    end

    // First requester at or after rr_ptr, wrapping explicitly so non-power-of-two counts work.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        cand     = rr_ptr;
        for (int i = 0; i < S_INTF_NUM; i++) begin
            if (!pick_vld && s_axis_tvalid[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
            cand = (cand == SEL_LAST) ? '0 : cand + SEL_WIDTH'(1);
        end
    end

    assign busy        = (state == BUSY);
    assign last_accept = busy & s_axis_tvalid[sel] & m_axis_tready & s_axis_tlast[sel];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    sel_nxt   = pick;
                end
            end
            BUSY: begin
                if (last_accept) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (sel == SEL_LAST) ? '0 : sel + SEL_WIDTH'(1);
                end
            end
        endcase
    end

    always_comb begin
        grant         = '0;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        if (state == BUSY) begin
            grant[sel]         = 1'b1;
            s_axis_tready[sel] = m_axis_tready;
            m_axis_tvalid      = s_axis_tvalid[sel];
        end
    end

    // Payload always follows sel so egress is never X, even in IDLE.
    assign m_axis_tdata = s_data[sel];
    assign m_axis_tkeep = s_keep[sel];
    assign m_axis_tuser = s_user[sel];
    assign m_axis_tlast = s_axis_tlast[sel];

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [31:0] cnt [S_INTF_NUM];

    // NOTE: the counter array is reset explicitly; it is small flop storage, not a RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < S_INTF_NUM; i++) cnt[i] <= '0;
        end else if (last_accept) begin
            cnt[sel] <= cnt[sel] + 32'd1;
        end
    end

    for (genvar i = 0; i < S_INTF_NUM; i++) begin : g_cnt
        assign pkt_cnt[i*32 +: 32] = cnt[i];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule
